uart_frame_reader: RTL and testbench
====================================

Name: uart_frame_reader

Overview:
- Parametrised successor to the single-byte UART read FSM.
- Drains a variable-length frame of 1..MAX_BYTES characters from the UART receiver holding register (rxempty/rxdata/uldrxdata handshake) and packs it into one wide output word.
- Adds an inter-byte timeout, a byte count, selectable packing order and a done/ack handshake.
- Sits between the UART RX core and the command/keypad decoding logic.

Parameters:
- DATA_W, 8: character width in bits.
- MAX_BYTES, 8: maximum frame length in characters.
- CNT_W, $clog2(MAX_BYTES+1): width of the length and count fields.
- TIMEOUT_CYC, 1000000: idle cycles allowed in POLL before aborting. 0 disables the timeout.
- LSB_FIRST, 1: 1 puts the first byte in the lowest slot; 0 puts the first byte in the highest-used slot (shift-in order).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin frame; sampled in IDLE or DONE
- len  in  CNT_W  bytes to collect; sampled on accepted start
- ack  in  1  consumer acknowledge; releases DONE
- rxempty  in  1  UART RX holding register empty
- rxdata  in  DATA_W  UART RX character, valid while rxempty=0
- uldrxdata  out  1  unload strobe to the UART RX core
- busy  out  1  frame collection in progress
- done  out  1  frame complete; held until ack or start
- timeout  out  1  frame ended by timeout; valid with done
- nbytes  out  CNT_W  bytes actually captured; valid with done
- frame  out  MAX_BYTES*DATA_W  packed frame; unfilled slots are 0

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; uldrxdata, busy, done, timeout=0; nbytes=0; frame=0; count=0; timer=0. Reset dominates every other input and aborts a frame mid-collection.
- All outputs are registered.
- States: IDLE, POLL, UNLOAD, GUARD, DONE.
- IDLE:
  - On start=1: latch len_q. len=0 is treated as 1; len>MAX_BYTES is clamped to MAX_BYTES.
  - Clear frame, count, timer and timeout; set busy=1; go to POLL.
  - Otherwise stay in IDLE. frame and nbytes hold their last values.
- POLL:
  - If rxempty=0: write rxdata into slot count; uldrxdata<=1; count<=count+1; timer<=0; go to UNLOAD.
  - Else if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1: timeout<=1; go to DONE.
  - Else timer<=timer+1.
- UNLOAD: uldrxdata is high for exactly this one cycle. Next: uldrxdata<=0; go to GUARD.
- GUARD:
  - One dead cycle so the RX core's rxempty update is seen; rxempty is ignored here.
  - If count==len_q, go to DONE; else go to POLL.
  - Minimum 3 cycles per byte.
- DONE:
  - done=1, busy=0, nbytes=count.
  - ack=1: go to IDLE and clear done. timeout, frame and nbytes hold.
  - start=1 (with or without ack): start has priority; restart exactly as from IDLE, done<=0 on the same edge.
- Packing:
  - LSB_FIRST=1: byte i goes to frame[i*DATA_W +: DATA_W].
  - LSB_FIRST=0: on each capture, frame <= {frame[MAX_BYTES*DATA_W-DATA_W-1:0], rxdata}, so the last byte lands in slot 0.
- start while busy is ignored. ack outside DONE is ignored.
- Timer width covers TIMEOUT_CYC-1. The timer never wraps.
- uldrxdata is never asserted outside UNLOAD. At most one uldrxdata pulse per captured byte.

Test Plan:
- Reset and idle: reset=0 for 2 cycles with rxempty=0 → all outputs 0, uldrxdata never pulses, state stays IDLE.
- Full LSB frame: LSB_FIRST=1, len=4; rxdata 0x31, 0x32, 0x33, 0x34 each presented with rxempty=0 → exactly 4 uldrxdata pulses, each 1 cycle wide and ≥3 cycles apart; then done=1, nbytes=4, frame[31:0]=0x34333231, upper bits 0, timeout=0.
- MSB packing: LSB_FIRST=0, len=2, bytes 0xAB then 0xCD → frame[15:0]=0xABCD.
- Timeout: TIMEOUT_CYC=16, len=3; send one byte 0x55, then hold rxempty=1 → done=1 exactly 16 cycles after POLL re-entry, timeout=1, nbytes=1, frame[7:0]=0x55.
- Boundaries: len=0 → collects 1 byte. len=MAX_BYTES+3 → collects MAX_BYTES bytes. start pulsed mid-frame → ignored.
- Handshake and abort:
  - In DONE, hold ack=0 for 10 cycles → done stays 1.
  - Assert start and ack together → new frame begins, done=0 next cycle.
  - reset=0 during UNLOAD → uldrxdata=0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/uart_frame_reader.sv
// Drains a 1..MAX_BYTES character frame from the UART RX holding register
// and packs it into one wide word, with inter-byte timeout and done/ack handshake.
module uart_frame_reader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_BYTES   = 8,
    parameter int unsigned CNT_W       = $clog2(MAX_BYTES + 1),
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned LSB_FIRST   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            len,
    input  logic                        ack,
    input  logic                        rxempty,
    input  logic [DATA_W-1:0]           rxdata,
    output logic                        uldrxdata,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [CNT_W-1:0]            nbytes,
    output logic [MAX_BYTES*DATA_W-1:0] frame
);

    localparam int unsigned FRAME_W = MAX_BYTES * DATA_W;
    localparam int unsigned TMR_MAX = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam int unsigned TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_UNLOAD,
        S_GUARD,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   nbytes_q, nbytes_d;
    logic               uld_q, uld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   len_eff_c;

    // Requested length clamped into 1..MAX_BYTES
    always_comb begin
        len_eff_c = len;
        if (len == '0) begin
            len_eff_c = CNT_W'(1);
        end else if (len > CNT_W'(MAX_BYTES)) begin
            len_eff_c = CNT_W'(MAX_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            frame_q   <= '0;
            nbytes_q  <= '0;
            uld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            nbytes_q  <= nbytes_d;
            uld_q     <= uld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        nbytes_d  = nbytes_q;
        uld_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A new start wins over ack when both arrive in DONE
                if (start) begin
                    len_d     = len_eff_c;
                    frame_d   = '0;
                    count_d   = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = S_POLL;
                end else if (state_q == S_DONE && ack) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_POLL: begin
                if (!rxempty) begin
                    if (LSB_FIRST != 0) begin
                        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                frame_d[i*DATA_W +: DATA_W] = rxdata;
                            end
                        end
                    end else begin
                        frame_d = (frame_q << DATA_W) | FRAME_W'(rxdata);
                    end
                    uld_d   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    timer_d = '0;
                    state_d = S_UNLOAD;
                end else if (TO_EN && timer_q == TMR_W'(TMR_MAX)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    nbytes_d  = count_q;
                    state_d   = S_DONE;
                end else if (timer_q != TMR_W'(TMR_MAX)) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_UNLOAD: begin
                state_d = S_GUARD;
            end
            S_GUARD: begin
                // rxempty is stale this cycle while the RX core reacts to the unload
                if (count_q == len_q) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    nbytes_d = count_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_POLL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign uldrxdata = uld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign nbytes    = nbytes_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_uart_frame_reader.sv
// Bench for uart_frame_reader: LSB-first and shift-in instances share one stimulus
// and are checked every cycle against a queue-based frame model.
module tb_uart_frame_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned MB = 8;
    localparam int unsigned CW = $clog2(MB + 1);
    localparam int unsigned TO = 16;
    localparam int unsigned FW = MB * DW;

    logic          clk = 1'b0;
    logic          reset, start, ack, rxempty;
    logic [CW-1:0] len;
    logic [DW-1:0] rxdata;

    logic          uld_l, busy_l, done_l, to_l;
    logic [CW-1:0] nb_l;
    logic [FW-1:0] fr_l;
    logic          uld_m, busy_m, done_m, to_m;
    logic [CW-1:0] nb_m;
    logic [FW-1:0] fr_m;

    uart_frame_reader #(.DATA_W(DW), .MAX_BYTES(MB), .CNT_W(CW), .TIMEOUT_CYC(TO), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .len(len), .ack(ack),
        .rxempty(rxempty), .rxdata(rxdata), .uldrxdata(uld_l), .busy(busy_l),
        .done(done_l), .timeout(to_l), .nbytes(nb_l), .frame(fr_l)
    );

    uart_frame_reader #(.DATA_W(DW), .MAX_BYTES(MB), .CNT_W(CW), .TIMEOUT_CYC(TO), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset(reset), .start(start), .len(len), .ack(ack),
        .rxempty(rxempty), .rxdata(rxdata), .uldrxdata(uld_m), .busy(busy_m),
        .done(done_m), .timeout(to_m), .nbytes(nb_m), .frame(fr_m)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: captured bytes in a queue plus phase relative to the last capture
    bit            m_active = 0, m_done = 0, m_to = 0;
    int            m_len = 0, m_since = 0, m_idle = 0, m_nb = 0;
    logic [DW-1:0] q[$];

    task automatic m_finish();
        m_active = 0;
        m_done   = 1;
        m_nb     = q.size();
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_active = 0; m_done = 0; m_to = 0; m_nb = 0; m_since = 0; m_idle = 0;
            q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_len    = (len == 0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
                q.delete();
                m_to     = 0;
                m_done   = 0;
                m_active = 1;
                m_since  = 0;
                m_idle   = 0;
            end else if (m_done && ack) begin
                m_done = 0;
            end
        end else if (m_since == 1) begin
            m_since = 2;
        end else if (m_since == 2) begin
            if (q.size() == m_len) m_finish();
            else m_since = 0;
        end else if (!rxempty) begin
            q.push_back(rxdata);
            m_since = 1;
            m_idle  = 0;
        end else if (m_idle == TO - 1) begin
            m_to = 1;
            m_finish();
        end else begin
            m_idle++;
        end
    end

    function automatic logic [FW-1:0] exp_frame(input bit lsb);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (lsb) f[i*DW +: DW] = q[i];
            else     f[i*DW +: DW] = q[q.size()-1-i];
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [FW-1:0] st_exp;
            st_exp = FW'({m_active && m_since == 1, m_active, m_done, m_to, CW'(m_nb)});
            chk("status_lsb", FW'({uld_l, busy_l, done_l, to_l, nb_l}), st_exp);
            chk("status_msb", FW'({uld_m, busy_m, done_m, to_m, nb_m}), st_exp);
            chk("frame_lsb", fr_l, exp_frame(1'b1));
            chk("frame_msb", fr_m, exp_frame(1'b0));
        end
        if (uld_l === 1'b1) pulses++;
    end

    task automatic start_frame(input int l);
        len   = CW'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        bit got = 0;
        rxdata  = b;
        rxempty = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (uld_l) got = 1;
        end
        rxempty = 1'b1;
        chk("uld_wait", FW'(got), FW'(1));
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = 0;
        while (!done_l && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_wait", FW'(done_l), FW'(1));
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, p0;
        reset = 1'b0; start = 1'b0; ack = 1'b0; rxempty = 1'b0; rxdata = 8'hEE; len = '0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", FW'({uld_l, busy_l, done_l, to_l, nb_l}), '0);
        chk("reset_frame", fr_l, '0);
        chk("reset_no_pulse", FW'(pulses), FW'(0));
        rxempty = 1'b1;
        reset   = 1'b1;
        @(negedge clk);

        // Four-byte frame, both packing orders
        p0 = pulses;
        start_frame(4);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
        wait_done(20, c);
        chk("lsb4_nbytes", FW'(nb_l), FW'(4));
        chk("lsb4_frame", fr_l, FW'(32'h34333231));
        chk("lsb4_frame_msb", fr_m, FW'(32'h31323334));
        chk("lsb4_timeout", FW'(to_l), FW'(0));
        chk("lsb4_pulses", FW'(pulses - p0), FW'(4));
        do_ack();
        chk("ack_clears_done", FW'(done_l), FW'(0));

        start_frame(2);
        send_byte(8'hAB); send_byte(8'hCD);
        wait_done(20, c);
        chk("msb2_frame", fr_m, FW'(16'hABCD));
        chk("msb2_frame_lsb", fr_l, FW'(16'hCDAB));
        do_ack();

        // Timeout after a single byte
        start_frame(3);
        send_byte(8'h55);
        wait_done(40, c);
        chk("to_latency", FW'(c), FW'(18));
        chk("to_flag", FW'(to_l), FW'(1));
        chk("to_nbytes", FW'(nb_l), FW'(1));
        chk("to_frame", fr_l, FW'(8'h55));
        repeat (10) @(negedge clk);
        chk("done_held", FW'(done_l), FW'(1));

        // start with ack in DONE restarts immediately
        len = CW'(1); start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("restart_done", FW'(done_l), FW'(0));
        chk("restart_busy", FW'(busy_l), FW'(1));
        chk("restart_to_clr", FW'(to_l), FW'(0));
        send_byte(8'h77);
        wait_done(20, c);
        chk("restart_frame", fr_l, FW'(8'h77));
        do_ack();

        // len=0 collects one byte and leaves the next one alone
        p0 = pulses;
        start_frame(0);
        send_byte(8'h9A);
        rxdata = 8'h9B; rxempty = 1'b0;
        wait_done(20, c);
        repeat (3) @(negedge clk);
        rxempty = 1'b1;
        chk("len0_nbytes", FW'(nb_l), FW'(1));
        chk("len0_pulses", FW'(pulses - p0), FW'(1));
        do_ack();

        // Oversized len clamps to MAX_BYTES; mid-frame start is ignored
        start_frame(MB + 3);
        for (int i = 1; i <= 3; i++) send_byte(DW'(i));
        start_frame(2);
        for (int i = 4; i <= 8; i++) send_byte(DW'(i));
        wait_done(20, c);
        chk("max_nbytes", FW'(nb_l), FW'(8));
        chk("max_frame_lsb", fr_l, 64'h0807060504030201);
        chk("max_frame_msb", fr_m, 64'h0102030405060708);
        chk("max_timeout", FW'(to_l), FW'(0));
        do_ack();

        // Reset while the unload strobe is high
        start_frame(2);
        send_byte(8'h42);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_uld", FW'(uld_l), FW'(0));
        chk("abort_outputs", FW'({busy_l, done_l, to_l, nb_l}), '0);
        chk("abort_frame", fr_l, '0);
        reset = 1'b1;
        p0 = pulses;
        rxempty = 1'b0;
        repeat (4) @(negedge clk);
        rxempty = 1'b1;
        chk("abort_idle_no_pulse", FW'(pulses - p0), FW'(0));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
